// File: rtl/fios_dsp_mult_sequencer.sv
// Column-wise (product-scanning) S x S limb multiply sequencer driving one
// non-cascaded DSP MAC slice with 17-bit limbs.
//
// Ports:
//   clock_i, rst_n_i     : clock, asynchronous active-low reset
//   start_i, a_i, b_i    : start pulse and operands (limb k at [17k+16:17k])
//   busy_o               : run in progress (through the done_o cycle)
//   dsp_A_o, dsp_B_o     : limb pair issued to the DSP A/B inputs
//   dsp_C_o, dsp_CREG_en_o : C path, tied off
//   dsp_OPMODE_o         : OPMODE aligned to the DSP pipeline
//   dsp_P_i              : DSP P output
//   res_valid_o, res_idx_o, res_word_o : one result limb per column
//   done_o               : pulses with the last limb (index 2S-1)
module fios_dsp_mult_sequencer #(
    parameter  int S     = 4,
    parameter  int ABREG = 1,
    parameter  int MREG  = 1,
    localparam int IW    = $clog2(2 * S)
) (
    input  logic            clock_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic [17*S-1:0] a_i,
    input  logic [17*S-1:0] b_i,
    output logic            busy_o,
    output logic [16:0]     dsp_A_o,
    output logic [16:0]     dsp_B_o,
    output logic [33:0]     dsp_C_o,
    output logic            dsp_CREG_en_o,
    output logic [8:0]      dsp_OPMODE_o,
    input  logic [33:0]     dsp_P_i,
    output logic            res_valid_o,
    output logic [IW-1:0]   res_idx_o,
    output logic [16:0]     res_word_o,
    output logic            done_o
);

    // OPMODE delay and P-tag delay, both counted from the operand register
    localparam int D = ABREG + MREG - 1;
    localparam int L = ABREG + MREG + 1;

    localparam logic [8:0] OP_IDLE   = 9'h000;
    localparam logic [8:0] OP_FIRST0 = 9'h005;
    localparam logic [8:0] OP_FIRSTK = 9'h065;
    localparam logic [8:0] OP_ACC    = 9'h025;
    localparam logic [8:0] OP_FLUSH  = 9'h060;

    localparam logic [IW-1:0] SM1    = IW'(S - 1);
    localparam logic [IW-1:0] K_LAST = IW'(2 * S - 2);
    localparam logic [IW-1:0] K_FLSH = IW'(2 * S - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        FLUSH,
        DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [17*S-1:0] a_q, b_q;
    logic [IW-1:0]   k_q, i_q;
    logic [IW-1:0]   i_lo, i_hi, j, k_nx, i_lo_nx;
    logic            first, last, last_slot;

    logic [16:0]   slot_a, slot_b;
    logic [8:0]    slot_op;
    logic          slot_tv;
    logic [IW-1:0] slot_tidx;

    logic [8:0]    op_pipe   [0:D];
    logic          tv_pipe   [0:L];
    logic [IW-1:0] tidx_pipe [0:L];

    logic unused_p_hi;
    assign unused_p_hi = ^dsp_P_i[33:17];

    assign busy_o        = (state_q != IDLE);
    assign dsp_C_o       = '0;
    assign dsp_CREG_en_o = 1'b0;
    assign dsp_OPMODE_o  = op_pipe[D];

    // Row bounds of the current column and of the next one
    always_comb begin
        i_lo      = (k_q > SM1) ? k_q - SM1 : '0;
        i_hi      = (k_q < SM1) ? k_q : SM1;
        j         = k_q - i_q;
        k_nx      = k_q + IW'(1);
        i_lo_nx   = (k_nx > SM1) ? k_nx - SM1 : '0;
        first     = (i_q == i_lo);
        last      = (i_q == i_hi);
        last_slot = last && (k_q == K_LAST);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = ISSUE;
            ISSUE:   if (last_slot) state_d = FLUSH;
            FLUSH:   state_d = DRAIN;
            DRAIN:   if (done_o) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        slot_a    = '0;
        slot_b    = '0;
        slot_op   = OP_IDLE;
        slot_tv   = 1'b0;
        slot_tidx = '0;
        if (state_q == ISSUE) begin
            slot_a    = a_q[17*int'(i_q) +: 17];
            slot_b    = b_q[17*int'(j) +: 17];
            slot_op   = !first ? OP_ACC :
                        (k_q == '0) ? OP_FIRST0 : OP_FIRSTK;
            slot_tv   = last;
            slot_tidx = k_q;
        end else if (state_q == FLUSH) begin
            slot_op   = OP_FLUSH;
            slot_tv   = 1'b1;
            slot_tidx = K_FLSH;
        end
    end

    always_ff @(posedge clock_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clock_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_q         <= '0;
            b_q         <= '0;
            k_q         <= '0;
            i_q         <= '0;
            dsp_A_o     <= '0;
            dsp_B_o     <= '0;
            res_valid_o <= 1'b0;
            res_idx_o   <= '0;
            res_word_o  <= '0;
            done_o      <= 1'b0;
            for (int n = 0; n <= D; n++) op_pipe[n] <= OP_IDLE;
            for (int n = 0; n <= L; n++) begin
                tv_pipe[n]   <= 1'b0;
                tidx_pipe[n] <= '0;
            end
        end else begin
            if (state_q == IDLE && start_i) begin
                a_q <= a_i;
                b_q <= b_i;
                k_q <= '0;
                i_q <= '0;
            end else if (state_q == ISSUE) begin
                if (last) begin
                    k_q <= k_nx;
                    i_q <= i_lo_nx;
                end else begin
                    i_q <= i_q + IW'(1);
                end
            end

            dsp_A_o      <= slot_a;
            dsp_B_o      <= slot_b;
            op_pipe[0]   <= slot_op;
            tv_pipe[0]   <= slot_tv;
            tidx_pipe[0] <= slot_tidx;
            for (int n = 1; n <= D; n++) op_pipe[n] <= op_pipe[n-1];
            for (int n = 1; n <= L; n++) begin
                tv_pipe[n]   <= tv_pipe[n-1];
                tidx_pipe[n] <= tidx_pipe[n-1];
            end

            // Tag at depth L marks the cycle dsp_P_i holds a finished column
            res_valid_o <= tv_pipe[L];
            done_o      <= tv_pipe[L] && (tidx_pipe[L] == K_FLSH);
            if (tv_pipe[L]) begin
                res_word_o <= dsp_P_i[16:0];
                res_idx_o  <= tidx_pipe[L];
            end
        end
    end

endmodule

// File: doc/fios_dsp_mult_sequencer.md
Name: fios_dsp_mult_sequencer

Overview:
- Sequences one non-cascaded DSP multiply-accumulate slice through a column-wise (product-scanning) S-limb × S-limb multiplication, using 17-bit limbs.
- Latches two operands of width 17*S on start and issues limb pairs to the DSP A/B inputs.
- Drives the DSP OPMODE with the same pipeline alignment as the DSP, and collects one 17-bit result limb per column from the DSP P output.
- Sits between the FIOS top-level control and one DSP_model-style slice; C path unused.

Parameters:
- S, 4, number of 17-bit limbs per operand (2..64).
- ABREG, 1, DSP A/B input register depth (0/1); must match the DSP instance.
- MREG, 1, DSP multiplier register depth (0/1); must match the DSP instance; ABREG+MREG ≥ 1 required.

Ports:
- clock_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle start pulse; ignored while busy_o=1
- a_i  in  17*S  operand A, limb k = a_i[17k+16:17k]
- b_i  in  17*S  operand B, same packing
- busy_o  out  1  high from cycle after accepted start until done_o cycle inclusive
- dsp_A_o  out  17  limb to DSP A_i
- dsp_B_o  out  17  limb to DSP B_i
- dsp_C_o  out  34  constant 0
- dsp_CREG_en_o  out  1  constant 0
- dsp_OPMODE_o  out  9  to DSP OPMODE_i
- dsp_P_i  in  34  from DSP P_o
- res_valid_o  out  1  result limb valid
- res_idx_o  out  $clog2(2S)  result limb index
- res_word_o  out  17  result limb
- done_o  out  1  one-cycle pulse with last limb (index 2S-1)

Behaviour:
- Reset (async, any time incl. mid-operation): all outputs 0, operand registers cleared, FSM→IDLE, opmode delay line cleared (idle OPMODE 0x000).
- FSM: IDLE → ISSUE on accepted start (a_i/b_i latched that edge) → FLUSH (1 slot) → DRAIN → IDLE once done_o is pulsed.
- Issue order: column k = 0..2S-2; within k, i = max(0,k-S+1)..min(k,S-1), j = k-i. One slot per cycle, S² slots, no bubbles. dsp_A_o=a[i], dsp_B_o=b[j] (registered). Outside ISSUE: 0.
- Per-slot OPMODE (W=00 always):
  - first slot of column 0: 0x005 (XY=M, Z=0)
  - first slot of column k>0: 0x065 (XY=M, Z=P>>17)
  - other slots: 0x025 (XY=M, Z=P)
  - FLUSH slot: 0x060 (XY=0, Z=P>>17)
  - idle: 0x000
- Alignment: operands of a slot are on dsp_A_o/B_o in cycle t. The matching OPMODE is on dsp_OPMODE_o in cycle t+ABREG+MREG-1, via a delay line of that depth. dsp_P_i reflects that slot in cycle t+1+ABREG+MREG (= DSP_REG_LEVEL).
- Capture: when the P reflecting the last slot of column k (or the FLUSH slot, k=2S-1) is on dsp_P_i, register res_word_o=dsp_P_i[16:0] and res_idx_o=k, with res_valid_o=1 the next cycle.
- Capture tracking uses a tag delay line, not recomputed timing.
- Limbs emitted in order 0..2S-1, exactly once each. done_o coincides with limb 2S-1; busy_o drops the following cycle.
- Width: internal DSP accumulator is 48 bits, so column sums up to S·(2^17-1)² + carry fit for S ≤ 64. The final limb is < 2^17 by construction.
- start_i while busy: ignored, no operand relatch. start_i in the same cycle as done_o: ignored. Accepted from the following cycle.
- Total latency, start edge to done_o: S²+1 issue slots + DSP_REG_LEVEL + 1 cycles.

Test Plan:
- S=2, a limbs {a0=2,a1=3}, b limbs {b0=5,b1=7}, start → OPMODE sequence 0x005,0x065,0x025,0x065,0x060 at alignment offset ABREG+MREG-1; res limbs idx0..3 = 10,29,21,0; done_o with idx3.
- S=2, all-ones operands (0x3FFFFFFFF) → res limbs 0x00001,0x00000,0x1FFFE,0x1FFFF; cross-check with big-int model.
- S=4, ABREG/MREG swept over {1,1},{0,1},{1,0} with random operands (1000 runs), against the generic DSP model → product matches; done_o at S²+1+DSP_REG_LEVEL+1 cycles after start.
- start_i pulsed every cycle during a run → single result stream, operands unchanged; start in the done_o cycle ignored, start next cycle accepted.
- rst_n_i asserted mid-ISSUE (async, between edges) → all outputs 0 immediately; after release, OPMODE 0x000 until a new start; the new run is correct.
- Back-to-back runs with S=3 → no limb of run 1 is emitted after run 2 starts; res_idx_o sequence 0..5 per run.
